// File: rtl/demux_dist.sv
// Word demultiplexer: explicit-select lane writes or auto frame fill with HOLD/ack handshake.
// Optional macro DEMUX_BITREV_EN writes auto-mode lanes in bit-reversed order.
module demux_dist #(
  parameter int WORD_SIZE = 16,
  parameter int N_OUT     = 4,
  parameter int SEL_W     = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mode,
  input  logic [SEL_W-1:0]           sel,
  input  logic [WORD_SIZE-1:0]       a,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [N_OUT*WORD_SIZE-1:0] out_bus,
  output logic [N_OUT-1:0]           lane_stb,
  output logic                       frame_valid,
  input  logic                       frame_ack
);

  typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

  state_t               state;
  logic [SEL_W-1:0]     wr_cnt;
  logic [SEL_W-1:0]     auto_idx_p0;
  logic [SEL_W-1:0]     wr_sel_p0;
  logic                 xfer_p0;
  logic [WORD_SIZE-1:0] lane_p1 [N_OUT];

`ifdef DEMUX_BITREV_EN
  function automatic logic [SEL_W-1:0] bit_rev(input logic [SEL_W-1:0] v);
    logic [SEL_W-1:0] r;
    for (int i = 0; i < SEL_W; i++) r[i] = v[SEL_W-1-i];
    return r;
  endfunction

  assign auto_idx_p0 = bit_rev(wr_cnt);
`else
  assign auto_idx_p0 = wr_cnt;
`endif

  // Explicit mode always accepts; auto mode accepts only while filling.
  assign in_ready    = ~rst & (~mode | (state == FILL));
  assign xfer_p0     = in_valid & in_ready;
  assign wr_sel_p0   = mode ? auto_idx_p0 : sel;
  assign frame_valid = mode & (state == HOLD);

  // ---- stage p0 -> p1: lane registers and write strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_OUT; k++) lane_p1[k] <= '0;
      lane_stb <= '0;
    end else begin
      lane_stb <= '0;
      if (xfer_p0) begin
        lane_p1[wr_sel_p0]  <= a;
        lane_stb[wr_sel_p0] <= 1'b1;
      end
    end
  end

  // Explicit mode pins the counter and state, so any mode change starts a fresh frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= FILL;
      wr_cnt <= '0;
    end else if (!mode) begin
      state  <= FILL;
      wr_cnt <= '0;
    end else begin
      case (state)
        FILL: begin
          if (xfer_p0) begin
            wr_cnt <= wr_cnt + SEL_W'(1);
            if (wr_cnt == SEL_W'(N_OUT - 1)) state <= HOLD;
          end
        end
        HOLD: begin
          if (frame_ack) state <= FILL;
        end
        default: state <= FILL;
      endcase
    end
  end

  for (genvar k = 0; k < N_OUT; k++) begin : g_bus
    assign out_bus[k*WORD_SIZE +: WORD_SIZE] = lane_p1[k];
  end

endmodule
